// File: rtl/pau_pkg.sv
// Shared PAU helpers: id sizing and format parameters.
// Used by every PAU sequencer that tags results with a requester id.
package pau_pkg;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int posit_es(input int w);
    case (w)
      16:      return 1;
      64:      return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int fp_ew(input int w);
    case (w)
      16:      return 5;
      64:      return 11;
      default: return 8;
    endcase
  endfunction

endpackage

// File: rtl/positToFp.sv
// Combinational posit to IEEE conversion, truncating.
// Maxpos has no regime terminator and saturates to infinity.
module positToFp
  import pau_pkg::*;
#(
  parameter int FPWID = 32
) (
  input  logic [FPWID-1:0] a,
  output logic [FPWID-1:0] o
);

  localparam int ES   = posit_es(FPWID);
  localparam int EW   = fp_ew(FPWID);
  localparam int MW   = FPWID - 1 - EW;
  localparam int BW   = FPWID - 1;
  localparam int RW   = $clog2(FPWID) + 1;
  localparam int SW   = EW + 3;
  localparam int BIAS = 2 ** (EW - 1) - 1;
  localparam logic [SW-1:0] EXP_MAX = SW'(2 ** EW - 1);

  logic          sgn;
  logic          rbit;
  logic          stop;
  logic [BW-1:0] body;
  logic [RW-1:0] run;
  logic [ES-1:0] ex;
  logic [MW-1:0] frac;
  logic [SW-1:0] runx;
  logic [SW-1:0] k;
  logic [SW-1:0] bexp;
  logic          max_reg;

  // decode regime/exponent/fraction and pack the IEEE word
  always_comb begin
    sgn  = a[FPWID-1];
    body = BW'(sgn ? -a : a);
    rbit = body[BW-1];
    run  = '0;
    stop = 1'b0;
    for (int j = BW - 1; j >= 0; j--) begin
      if (!stop) begin
        if (body[j] == rbit) run = run + RW'(1);
        else stop = 1'b1;
      end
    end
    {ex, frac} = (ES + MW)'(((body << run) << 1) >> (BW - ES - MW));
    runx    = SW'(run);
    k       = rbit ? runx - SW'(1) : -runx;
    bexp    = (k << ES) + SW'(ex) + SW'(BIAS);
    max_reg = rbit && (run == RW'(BW));
    if (a == '0) begin
      o = '0;
    end else if (a == {1'b1, {BW{1'b0}}}) begin
      o = {1'b1, {EW{1'b1}}, {MW{1'b0}}};
    end else if (max_reg || (!bexp[SW-1] && bexp >= EXP_MAX)) begin
      o = {sgn, {EW{1'b1}}, {MW{1'b0}}};
    end else if (bexp[SW-1] || bexp == '0) begin
      o = {sgn, {(FPWID-1){1'b0}}};
    end else begin
      o = {sgn, bexp[EW-1:0], frac};
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, one grant per cycle.
// Pointer moves past the winner; unchanged without a grant.
module rr_arbiter
  import pau_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2_min1(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW:0]   sum;
  logic [IW-1:0] pos;
  logic          hit;

  // search upward from the pointer with wrap
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    hit   = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, ptr_q} + (IW + 1)'(off);
      if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
      pos = IW'(sum);
      if (en_i && !hit && req_i[pos]) begin
        hit        = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
    ptr_d = ptr_q;
    if (hit) ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + IW'(1);
  end

  // pointer register
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/posit_cvt_arbiter.sv
// One shared positToFp behind a round-robin arbiter.
// Results return LAT cycles after ack, tagged with requester id.
module posit_cvt_arbiter
  import pau_pkg::*;
#(
  parameter  int FPWID = 32,
  parameter  int NREQ  = 4,
  parameter  int LAT   = 2,
  localparam int IDW   = clog2_min1(NREQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*FPWID-1:0] a_i,
  output logic [NREQ-1:0]       ack_o,
  output logic [NREQ-1:0]       busy_o,
  output logic                  vld_o,
  output logic [IDW-1:0]        id_o,
  output logic [FPWID-1:0]      o
);

  typedef struct packed {
    logic             vld;
    logic [IDW-1:0]   id;
    logic [FPWID-1:0] data;
  } stage_t;

  logic [NREQ-1:0]  busy_q;
  logic [NREQ-1:0]  busy_d;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gidx;
  logic [FPWID-1:0] opnd;
  logic [FPWID-1:0] cvt;
  logic             take;
  stage_t           stg_q [LAT];
  stage_t           stg_d [LAT];

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (~flush_i & ~rst_i),
    .req_i (req_i & ~busy_q),
    .gnt_o (gnt),
    .idx_o (gidx)
  );

  // select the granted operand
  always_comb begin
    opnd = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k]) opnd = a_i[k*FPWID +: FPWID];
    end
  end

  positToFp #(.FPWID(FPWID)) u_cvt (
    .a (opnd),
    .o (cvt)
  );

  // shift stages; data loads only behind a valid so outputs hold
  always_comb begin
    take         = |gnt;
    stg_d        = stg_q;
    stg_d[0].vld = take;
    if (take) begin
      stg_d[0].id   = gidx;
      stg_d[0].data = cvt;
    end
    for (int s = 1; s < LAT; s++) begin
      stg_d[s].vld = stg_q[s-1].vld;
      if (stg_q[s-1].vld) begin
        stg_d[s].id   = stg_q[s-1].id;
        stg_d[s].data = stg_q[s-1].data;
      end
    end
    if (flush_i) begin
      for (int s = 0; s < LAT; s++) stg_d[s].vld = 1'b0;
    end
  end

  // busy: set on grant, clear as the result leaves
  always_comb begin
    busy_d = busy_q;
    if (stg_q[LAT-1].vld) busy_d[stg_q[LAT-1].id] = 1'b0;
    busy_d = busy_d | gnt;
    if (flush_i) busy_d = '0;
  end

  // state registers; only valids and the output stage reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < LAT; s++) stg_q[s].vld <= 1'b0;
      stg_q[LAT-1].id   <= '0;
      stg_q[LAT-1].data <= '0;
      busy_q            <= '0;
    end else begin
      stg_q  <= stg_d;
      busy_q <= busy_d;
    end
  end

  assign ack_o  = gnt;
  assign busy_o = busy_q;
  assign vld_o  = stg_q[LAT-1].vld;
  assign id_o   = stg_q[LAT-1].id;
  assign o      = stg_q[LAT-1].data;

endmodule
